// File: rtl/feed_arb_pkg.sv
// Shared types and width helpers for the feed record arbiter.
package feed_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN
  } arb_state_t;

  localparam logic [7:0] EOR_DEFAULT = 8'd10;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/feed_record_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import feed_arb_pkg::*;
#(
  parameter int NUM_FEEDS = 4,
  parameter int ID_W      = id_width(NUM_FEEDS)
) (
  input  logic [NUM_FEEDS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [ID_W-1:0]      grant,
  output logic                 any_req
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int i = NUM_FEEDS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_FEEDS) idx = idx - NUM_FEEDS;
      if (req[idx]) begin
        grant   = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/feed_record_arbiter.sv
// Grants whole EOR-delimited records from NUM_FEEDS byte feeds to one parser,
// round-robin, with a parser clear before each record and cut-off of long ones.
module feed_record_arbiter
  import feed_arb_pkg::*;
#(
  parameter int         NUM_FEEDS   = 4,
  parameter int         MAX_REC_LEN = 255,
  parameter logic [7:0] EOR_CHAR    = EOR_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_FEEDS*8-1:0]              feed_char,
  input  logic [NUM_FEEDS-1:0]                feed_valid,
  output logic [NUM_FEEDS-1:0]                feed_ready,
  output logic [7:0]                          char_out,
  output logic                                valid_out,
  output logic                                parser_clear,
  output logic [id_width(NUM_FEEDS)-1:0]      grant_id,
  output logic                                rec_done,
  output logic [cnt_width(MAX_REC_LEN)-1:0]   rec_len,
  output logic                                rec_abort,
  output logic                                busy
);

  localparam int ID_W  = id_width(NUM_FEEDS);
  localparam int CNT_W = cnt_width(MAX_REC_LEN);

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pick;
  logic             any_req;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       feed_bytes [NUM_FEEDS];
  logic [7:0]       cur_char;
  logic             granted_phase;
  logic             accept;

  for (genvar g = 0; g < NUM_FEEDS; g++) begin : g_bytes
    assign feed_bytes[g] = feed_char[8*g +: 8];
  end

  rr_arbiter #(
    .NUM_FEEDS(NUM_FEEDS),
    .ID_W     (ID_W)
  ) u_rr (
    .req    (feed_valid),
    .ptr    (ptr),
    .grant  (pick),
    .any_req(any_req)
  );

  assign granted_phase = (state == ST_STREAM) || (state == ST_DRAIN);
  assign cur_char      = feed_bytes[grant_id];
  assign accept        = granted_phase && feed_valid[grant_id];
  assign cnt_inc       = cnt + 1'b1;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    feed_ready = '0;
    if (granted_phase) feed_ready[grant_id] = 1'b1;
  end

  // NOTE: the async reset clears only control and output registers; there is
  // no storage array here that would need it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      cnt          <= '0;
      char_out     <= '0;
      valid_out    <= 1'b0;
      parser_clear <= 1'b0;
      rec_done     <= 1'b0;
      rec_len      <= '0;
      rec_abort    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      valid_out    <= 1'b0;
      parser_clear <= 1'b0;
      rec_done     <= 1'b0;
      rec_len      <= '0;
      rec_abort    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_id     <= pick;
            ptr          <= (pick == ID_W'(NUM_FEEDS - 1)) ? '0 : pick + 1'b1;
            cnt          <= '0;
            parser_clear <= 1'b1;
            state        <= ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_STREAM;
        ST_STREAM: begin
          if (accept) begin
            cnt <= cnt_inc;
            // EOR is tested first so a full-length record ending in EOR completes.
            if (cur_char == EOR_CHAR) begin
              char_out  <= cur_char;
              valid_out <= 1'b1;
              rec_done  <= 1'b1;
              rec_len   <= cnt_inc;
              state     <= ST_IDLE;
            end else if (cnt_inc == CNT_W'(MAX_REC_LEN)) begin
              rec_abort <= 1'b1;
              state     <= ST_DRAIN;
            end else begin
              char_out  <= cur_char;
              valid_out <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && cur_char == EOR_CHAR) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feed_record_arbiter.sv
// Directed bench: one default arbiter and one with MAX_REC_LEN=8, shared feeds.
module tb_feed_record_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] feed_char = '0;
  logic [3:0]  feed_valid = '0;

  logic [3:0] feed_ready0, feed_ready8;
  logic [7:0] char_out0, char_out8;
  logic       valid_out0, valid_out8, parser_clear0, parser_clear8;
  logic [1:0] grant_id0, grant_id8;
  logic       rec_done0, rec_done8, rec_abort0, rec_abort8, busy0, busy8;
  logic [7:0] rec_len0;
  logic [3:0] rec_len8;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int m_char[$], m_cyc[$], m_gnt[$], m_len[$], m_rgnt[$], m_clr[$], m_abort[$];
  int s_char[$], s_cyc[$], s_len[$], s_abort[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  feed_record_arbiter dut (
    .clk(clk), .reset_n(reset_n), .feed_char(feed_char), .feed_valid(feed_valid),
    .feed_ready(feed_ready0), .char_out(char_out0), .valid_out(valid_out0),
    .parser_clear(parser_clear0), .grant_id(grant_id0), .rec_done(rec_done0),
    .rec_len(rec_len0), .rec_abort(rec_abort0), .busy(busy0)
  );

  feed_record_arbiter #(.MAX_REC_LEN(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .feed_char(feed_char), .feed_valid(feed_valid),
    .feed_ready(feed_ready8), .char_out(char_out8), .valid_out(valid_out8),
    .parser_clear(parser_clear8), .grant_id(grant_id8), .rec_done(rec_done8),
    .rec_len(rec_len8), .rec_abort(rec_abort8), .busy(busy8)
  );

  always @(negedge clk) begin
    if (valid_out0) begin
      m_char.push_back(int'(char_out0)); m_cyc.push_back(cyc); m_gnt.push_back(int'(grant_id0));
    end
    if (rec_done0) begin m_len.push_back(int'(rec_len0)); m_rgnt.push_back(int'(grant_id0)); end
    if (parser_clear0) m_clr.push_back(cyc);
    if (rec_abort0) m_abort.push_back(cyc);
    if (valid_out8) begin s_char.push_back(int'(char_out8)); s_cyc.push_back(cyc); end
    if (rec_done8) s_len.push_back(int'(rec_len8));
    if (rec_abort8) s_abort.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    m_char.delete(); m_cyc.delete(); m_gnt.delete(); m_len.delete();
    m_rgnt.delete(); m_clr.delete(); m_abort.delete();
    s_char.delete(); s_cyc.delete(); s_len.delete(); s_abort.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(1);
  endtask

  // Presents each byte of s on feed f and advances once the chosen DUT accepts it.
  task automatic send(input int f, input string s, input bit use8);
    int waits;
    bit rdy;
    for (int i = 0; i < s.len(); i++) begin
      feed_char[8*f +: 8] = s[i];
      feed_valid[f] = 1'b1;
      waits = 0;
      rdy = 1'b0;
      while (!rdy && waits < 200) begin
        @(negedge clk);
        rdy = use8 ? feed_ready8[f] : feed_ready0[f];
        waits++;
      end
      if (!rdy) begin
        check($sformatf("handshake_timeout_feed%0d", f), 32'd0, 32'd1);
        feed_valid[f] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    feed_valid[f] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string s1;
    string pat;
    int r, j;

    // Reset state
    idle(2);
    check("rst_valid_out", valid_out0, 0);
    check("rst_busy", busy0, 0);
    check("rst_ready", feed_ready0, 0);
    check("rst_grant", grant_id0, 0);
    check("rst_clear", parser_clear0, 0);
    reset_n = 1'b1;
    idle(2);

    // Single feed record
    clear_logs();
    s1 = "A,B,100,25,7\n";
    send(0, s1, 1'b0);
    idle(6);
    check("t1_clears", m_clr.size(), 1);
    check("t1_nbytes", m_char.size(), 13);
    for (int i = 0; i < 13; i++) check($sformatf("t1_byte%0d", i), m_char[i], int'(s1[i]));
    check("t1_nrec", m_len.size(), 1);
    check("t1_len", m_len[0], 13);
    check("t1_grant", m_rgnt[0], 0);
    check("t1_clear_lead", m_cyc[0] - m_clr[0], 2);
    check("t1_abort", m_abort.size(), 0);
    check("t1_idle", busy0, 0);

    // Round-robin fairness
    do_reset();
    clear_logs();
    fork
      send(0, "abcd\nefgh\n", 1'b0);
      send(1, "abcd\nefgh\n", 1'b0);
      send(2, "abcd\nefgh\n", 1'b0);
      send(3, "abcd\nefgh\n", 1'b0);
    join
    idle(6);
    check("t2_nrec", m_len.size(), 8);
    check("t2_nbytes", m_char.size(), 40);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_rec%0d_grant", k), m_rgnt[k], k % 4);
      check($sformatf("t2_rec%0d_len", k), m_len[k], 5);
      if (k > 0) check($sformatf("t2_rec%0d_gap", k), m_cyc[5*k] - m_cyc[5*k-1], 3);
    end
    for (int k = 0; k < 40; k++) begin
      r = k / 5;
      j = k % 5;
      pat = (r < 4) ? "abcd\n" : "efgh\n";
      check($sformatf("t2_byte%0d", k), m_char[k], int'(pat[j]));
      check($sformatf("t2_byte%0d_grant", k), m_gnt[k], r % 4);
    end

    // Truncation on the short-limit instance
    do_reset();
    clear_logs();
    s1 = "abcdefghijkl\n";
    send(1, s1, 1'b1);
    idle(6);
    check("t3_nbytes", s_char.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("t3_byte%0d", i), s_char[i], int'(s1[i]));
    check("t3_naborts", s_abort.size(), 1);
    if (s_cyc.size() >= 7 && s_abort.size() >= 1)
      check("t3_abort_time", s_abort[0], s_cyc[6] + 1);
    check("t3_nrec", s_len.size(), 0);
    check("t3_idle", busy8, 0);

    // Exact-length record straight after the drain
    clear_logs();
    send(2, "1234567\n", 1'b1);
    idle(6);
    check("t4_nrec", s_len.size(), 1);
    check("t4_len", s_len[0], 8);
    check("t4_abort", s_abort.size(), 0);
    check("t4_nbytes", s_char.size(), 8);

    // Stall mid-record, with another feed requesting meanwhile
    do_reset();
    clear_logs();
    send(2, "xy,1", 1'b0);
    feed_char[8*3 +: 8] = "Z";
    feed_valid[3] = 1'b1;
    idle(10);
    check("t5_stall_bytes", m_char.size(), 4);
    check("t5_stall_grant", grant_id0, 2);
    check("t5_stall_ready", feed_ready0, 4'b0100);
    check("t5_stall_busy", busy0, 1);
    feed_valid[3] = 1'b0;
    s1 = "xy,1,2\n";
    send(2, ",2\n", 1'b0);
    idle(6);
    check("t5_nbytes", m_char.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("t5_byte%0d", i), m_char[i], int'(s1[i]));
    check("t5_len", m_len[0], 7);
    check("t5_grant", m_rgnt[0], 2);
    check("t5_clears", m_clr.size(), 1);

    // Reset in the middle of a record
    send(1, "abc", 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", valid_out0, 0);
    check("t6_rst_char", char_out0, 0);
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_grant", grant_id0, 0);
    check("t6_rst_ready", feed_ready0, 0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    clear_logs();
    fork
      send(3, "p\n", 1'b0);
      send(0, "q\n", 1'b0);
    join
    idle(6);
    check("t6_nrec", m_len.size(), 2);
    check("t6_first_grant", m_rgnt[0], 0);
    check("t6_second_grant", m_rgnt[1], 3);
    check("t6_clears", m_clr.size(), 2);
    check("t6_clear_lead", m_cyc[0] - m_clr[0], 2);
    check("t6_first_byte", m_char[0], int'(8'h71));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
